rs_syndrome_calc: RTL

//   First stage of the RS(15,11) decoder over GF(2^4). Sits directly downstream of the

---
 rtl/rs_pkg.sv | 28 ++
 rtl/rs_syndrome_calc_if.sv | 24 ++
 rtl/rs_syndrome_calc_gf16_mul.sv | 24 ++
 rtl/rs_syndrome_calc.sv | 104 ++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// Shared RS(15,11) / GF(2^4) definitions used by the encoder and every decoder stage.
package rs_pkg;

    localparam int M     = 4;
    localparam int N     = 15;
    localparam int K     = 11;
    localparam int NSYN  = N - K;
    localparam int FCR   = 1;
    localparam int CNT_W = 4;

    localparam logic [M:0]   PRIM_POLY = 5'b10011;
    localparam logic [M-1:0] POLY_LOW  = PRIM_POLY[M-1:0];

    // alpha^i for i = 0..14, alpha = x over x^4+x+1
    localparam logic [M-1:0] ALPHA_POW [0:N-1] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    typedef logic [M-1:0]      sym_t;
    typedef logic [NSYN*M-1:0] syn_vec_t;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } state_t;

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol-stream input and syndrome-result output of the RS syndrome stage.
interface rs_syndrome_calc_if;
    import rs_pkg::*;

    logic     sof;
    logic     sym_valid;
    sym_t     sym_in;
    syn_vec_t syn_out;
    logic     syn_valid;
    logic     err_flag;
    logic     busy;
    logic     frame_abort;

    modport master (
        output sof, sym_valid, sym_in,
        input  syn_out, syn_valid, err_flag, busy, frame_abort
    );

    modport slave (
        input  sof, sym_valid, sym_in,
        output syn_out, syn_valid, err_flag, busy, frame_abort
    );

endinterface

// File: rtl/rs_syndrome_calc_gf16_mul.sv
// Combinational GF(2^4) multiplier: shift-and-add with reduction by x^4+x+1.
module gf16_mul
    import rs_pkg::*;
(
    input  sym_t a,
    input  sym_t b,
    output sym_t p
);

    sym_t prod;
    sym_t shifted;

    // NOTE: blocking assignments here build a combinational chain inside one evaluation.
    always_comb begin
        prod    = '0;
        shifted = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) prod = prod ^ shifted;
            shifted = shifted[M-1] ? ((shifted << 1) ^ POLY_LOW) : (shifted << 1);
        end
        p = prod;
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,11) syndrome calculator: Horner evaluation of the received word at alpha^1..alpha^4.
module rs_syndrome_calc
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    rs_syndrome_calc_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sym_t             acc_q [NSYN];
    sym_t             acc_d [NSYN];
    sym_t             mul_out [NSYN];
    syn_vec_t         syn_out_q, syn_out_d;
    logic             syn_valid_q, syn_valid_d;
    logic             err_flag_q, err_flag_d;
    logic             frame_abort_q, frame_abort_d;

    logic start;
    logic last_sym;

    assign start    = bus.sof & bus.sym_valid;
    assign last_sym = (state_q == ST_ACCUM) & bus.sym_valid & ~bus.sof & (cnt_q == LAST_CNT);

    for (genvar g = 0; g < NSYN; g++) begin : g_syn
        gf16_mul u_mul (
            .a (acc_q[g]),
            .b (ALPHA_POW[FCR + g]),
            .p (mul_out[g])
        );
    end

    // NOTE: non-blocking assignments for every flop so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_ACCUM;
            ST_ACCUM: if (last_sym) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q == ST_ACCUM);
        bus.syn_out     = syn_out_q;
        bus.syn_valid   = syn_valid_q;
        bus.err_flag    = err_flag_q;
        bus.frame_abort = frame_abort_q;
    end

    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        syn_out_d     = syn_out_q;
        syn_valid_d   = 1'b0;
        err_flag_d    = err_flag_q;
        frame_abort_d = 1'b0;

        if (start) begin
            // An sof arriving mid-frame throws the partial frame away and restarts.
            for (int g = 0; g < NSYN; g++) acc_d[g] = bus.sym_in;
            cnt_d         = CNT_W'(1);
            frame_abort_d = (state_q == ST_ACCUM);
        end else if ((state_q == ST_ACCUM) && bus.sym_valid) begin
            for (int g = 0; g < NSYN; g++) acc_d[g] = mul_out[g] ^ bus.sym_in;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_sym) begin
                for (int g = 0; g < NSYN; g++) syn_out_d[g*M +: M] = acc_d[g];
                syn_valid_d = 1'b1;
                err_flag_d  = |syn_out_d;
                cnt_d       = '0;
            end
        end
    end

    // NOTE: the accumulator array is only NSYN registers, so it is reset along with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            acc_q         <= '{default: '0};
            syn_out_q     <= '0;
            syn_valid_q   <= 1'b0;
            err_flag_q    <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            syn_out_q     <= syn_out_d;
            syn_valid_q   <= syn_valid_d;
            err_flag_q    <= err_flag_d;
            frame_abort_q <= frame_abort_d;
        end
    end

endmodule
